// File: rtl/serial_subtractor_16b_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_16b_pkg;

  localparam int DEF_WIDTH = 16;

  // Counter must be able to hold WIDTH itself (it increments past the
  // terminal count on the last SHIFT edge), hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_16b_if.sv
// Request/result bundle for the bit-serial subtractor.
// master: the requester (drives start/A/B); slave: the subtractor.
interface serial_subtractor_16b_if
  import serial_subtractor_16b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow_out;
  logic             Zero;
  logic             Ovf;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Borrow_out, Zero, Ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borrow_out, Zero, Ovf
  );

endinterface

// File: rtl/serial_subtractor_16b_full_subtractor_1b.sv
// One-bit full subtractor cell: D = A - B - B_in, with borrow out.
// Borrow is formed as a NAND-NAND sum of the generate term (~A & B)
// and the propagate term (~(A ^ B) & B_in).
module full_subtractor_1b (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic D,
  output logic B_out
);

  logic ab_x;
  logic n_gen;
  logic n_prop;

  assign ab_x  = A ^ B;
  assign D     = ab_x ^ B_in;
  assign n_gen  = ~(~A & B);
  assign n_prop = ~(~ab_x & B_in);
  assign B_out  = ~(n_gen & n_prop);

endmodule

// File: rtl/serial_subtractor_16b.sv
// Bit-serial two's-complement subtractor: Diff = A - B, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// Optional signed-overflow flag is built when SERIAL_SUB_OVF_EN is defined;
// otherwise Ovf is tied low.
module serial_subtractor_16b
  import serial_subtractor_16b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_16b_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  full_subtractor_1b u_cell (
    .A     (opa_q[0]),
    .B     (opb_q[0]),
    .B_in  (bin_q),
    .D     (cell_d),
    .B_out (cell_bout)
  );

  // A request is only honoured when no operation is in flight.
  assign accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, shift one bit per SHIFT cycle,
  // publish the result only on the last bit so outputs stay stable otherwise.
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    res_d  = res_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    zero_d = zero_q;
    if (accept) begin
      opa_d = bus.A;
      opb_d = bus.B;
      res_d = '0;
      bin_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      opa_d = opa_q >> 1;
      opb_d = opb_q >> 1;
      res_d = res_next;
      bin_d = cell_bout;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_d = res_next;
        bout_d = cell_bout;
        zero_d = (res_next == '0);
      end
    end
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic ovf_q, ovf_d;

  // Operand sign bits are kept aside because the shift registers lose them.
  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    ovf_d = ovf_q;
    if (accept) begin
      sa_d = bus.A[WIDTH-1];
      sb_d = bus.B[WIDTH-1];
    end
    if (last_bit) ovf_d = (sa_q != sb_q) && (cell_d != sa_q);
  end

  // Sign and overflow flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Ovf = ovf_q;
`else
  assign bus.Ovf = 1'b0;
`endif

  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.Diff       = diff_q;
  assign bus.Borrow_out = bout_q;
  assign bus.Zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor_16b.sv
// Directed bench for serial_subtractor_16b: vector table plus hand-written
// sequences for start-while-busy, back-to-back and mid-run reset.
module tb_serial_subtractor_16b;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_16b_if #(.WIDTH(16)) bus ();

  serial_subtractor_16b #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;   // signed overflow when the flag is built in
  } vec_t;

  vec_t vecs [10];

  function automatic logic exp_ovf(input logic o);
`ifdef SERIAL_SUB_OVF_EN
    return o;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start from IDLE; returns at the negedge after accept.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
  endtask

  // Wait (bounded) for done. lat counts negedges since accept (1 = first).
  task automatic wait_done(input int lat0, output int lat, output int busy_n,
                           output bit changed);
    logic [15:0] prev;
    prev    = bus.Diff;
    lat     = lat0;
    busy_n  = 0;
    changed = 1'b0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (bus.Diff !== prev) changed = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int busy_n;
  bit changed;
  int done_seen;
  int busy_seen;

  initial begin
    vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.Diff), 32'h0);
    chk("rst_borrow", 32'(bus.Borrow_out), 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd1);
    chk("rst_ovf", 32'(bus.Ovf), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(1, lat, busy_n, changed);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd17);
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd16);
      chk($sformatf("v%0d_diff_stable", i), 32'(changed), 32'd0);
      chk($sformatf("v%0d_diff", i), 32'(bus.Diff), 32'(vecs[i].diff));
      chk($sformatf("v%0d_borrow", i), 32'(bus.Borrow_out), 32'(vecs[i].bout));
      chk($sformatf("v%0d_zero", i), 32'(bus.Zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d_ovf", i), 32'(bus.Ovf), 32'(exp_ovf(vecs[i].ovf)));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Start while busy must be ignored.
    launch(16'h0005, 16'h0003);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, lat, busy_n, changed);
    chk("ign_latency", 32'(lat), 32'd17);
    chk("ign_diff", 32'(bus.Diff), 32'h0002);
    chk("ign_borrow", 32'(bus.Borrow_out), 32'd0);

    // Back-to-back: start held in DONE goes straight to SHIFT.
    bus.start = 1'b1;
    bus.A     = 16'h0009;
    bus.B     = 16'h0004;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_no_done", 32'(bus.done), 32'd0);
    chk("b2b_diff_held", 32'(bus.Diff), 32'h0002);
    wait_done(1, lat, busy_n, changed);
    chk("b2b_latency", 32'(lat), 32'd17);
    chk("b2b_diff_stable", 32'(changed), 32'd0);
    chk("b2b_diff", 32'(bus.Diff), 32'h0005);
    chk("b2b_zero", 32'(bus.Zero), 32'd0);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    launch(16'h0007, 16'h0001);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_diff", 32'(bus.Diff), 32'h0);
    chk("mid_rst_borrow", 32'(bus.Borrow_out), 32'd0);
    chk("mid_rst_zero", 32'(bus.Zero), 32'd1);
    chk("mid_rst_ovf", 32'(bus.Ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    chk("post_rst_no_done", 32'(done_seen), 32'd0);
    chk("post_rst_no_busy", 32'(busy_seen), 32'd0);

    launch(16'h0007, 16'h0001);
    wait_done(1, lat, busy_n, changed);
    chk("rerun_latency", 32'(lat), 32'd17);
    chk("rerun_diff", 32'(bus.Diff), 32'h0006);
    chk("rerun_borrow", 32'(bus.Borrow_out), 32'd0);
    chk("rerun_zero", 32'(bus.Zero), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_16b.md
Name: serial_subtractor_16b

Overview:
Multi-cycle, bit-serial two's-complement subtractor. It computes Diff = A - B one bit per clock, LSB first, using a single 1-bit full-subtractor cell, a borrow flop and operand shift registers. It is the subtraction counterpart of the ripple adder datapath. It serves as an area-reduced SUB/compare unit for the ALU and branch-compare paths, with a start/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
A  input  WIDTH  minuend; captured on the accepting edge
B  input  WIDTH  subtrahend; captured on the accepting edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when the result is valid
Diff  output  WIDTH  A - B, modulo 2^WIDTH; held until next completion
Borrow_out  output  1  final borrow; 1 iff A < B unsigned
Zero  output  1  Diff == 0
Ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, Diff=0, Borrow_out=0, Zero=1, Ovf=0. Internal shift regs, borrow flop and counter = 0. Asserting rst in any state, including mid-SHIFT, aborts the operation; the partial result is discarded.
- States: IDLE, SHIFT, DONE. Encoding is internal.
- IDLE: if start=1 at an edge, latch A and B into opA/opB, clear the borrow flop and bit counter, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT (busy=1), each edge:
  - d = opA[0] ^ opB[0] ^ bin
  - bout = (~opA[0] & opB[0]) | (~(opA[0] ^ opB[0]) & bin)
  - d is shifted into the MSB of the result shift register; opA and opB shift right by 1; bin <= bout; counter++.
- On the edge that processes bit WIDTH-1:
  - copy the completed result to Diff; set Borrow_out=bout and Zero=(result==0); set Ovf when enabled.
  - go to DONE.
- DONE: done=1 for exactly this cycle. start=1 here is accepted like in IDLE (back-to-back: go to SHIFT). Otherwise go to IDLE.
- Latency: start accepted at edge t; done is high in the cycle following edge t+WIDTH (WIDTH+1 edges from accept to done deassertion). Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored and not queued. A and B may change freely after the accepting edge.
- Diff, Borrow_out, Zero and Ovf change only at the completion edge or at reset. They are stable at all other times.
- Wrap-around: 0x0000 - 0x0001 = 0xFFFF with Borrow_out=1. No saturation.
- Counter width is clog2(WIDTH)+1 bits; the terminal count is WIDTH-1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: Ovf is registered at completion as (A[msb] != B[msb]) && (Diff[msb] != A[msb]), using the captured operand sign bits held in two extra flops.
- Undefined: the sign flops and logic are omitted, and Ovf is tied to 0 (port still present).

Decomposition:
- Shared package: state encoding constants (IDLE/SHIFT/DONE), default WIDTH, and the counter width constant.
- Sub-module full_subtractor_1b (inputs A, B, B_in; outputs D, B_out), built from xor3/nand-style gates. It is instantiated once for the serial bit cell.

Test Plan:
- A=0x0005, B=0x0003, start pulse → done one cycle after the 16th SHIFT edge; Diff=0x0002, Borrow_out=0, Zero=0, Ovf=0; busy high exactly 16 cycles.
- A=0x0003, B=0x0005 → Diff=0xFFFE, Borrow_out=1, Zero=0, Ovf=0.
- A=0x1234, B=0x1234 → Diff=0x0000, Zero=1, Borrow_out=0.
- A=0x8000, B=0x0001 → Diff=0x7FFF, Borrow_out=0, Ovf=1 with SERIAL_SUB_OVF_EN, Ovf=0 without.
- Start 5-3; re-pulse start with A=0xFFFF, B=0 at SHIFT cycle 4 → ignored, result 0x0002. Then hold start high in DONE with 9-4 → back-to-back run yields 0x0005, and the prior Diff is held during the run.
- Start 7-1; assert rst at SHIFT cycle 8 → all outputs go to reset values immediately (Zero=1); no done pulse follows; a new start after release gives a correct result.
